// File: rtl/i2c_reg_sequencer.sv
// Register read/write sequencer that drives an AXI-stream style I2C master (cmd/tx/rx channels).
// Define I2C_REG_SEQUENCER_RETRY_EN to retry NACKed accesses up to RETRY_MAX extra times.
module i2c_reg_sequencer #(
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_read,
  input  logic [6:0] req_dev_addr,
  input  logic [7:0] req_reg_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic [6:0] cmd_address,
  output logic       cmd_start,
  output logic       cmd_read,
  output logic       cmd_write,
  output logic       cmd_stop,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] tx_tdata,
  output logic       tx_tvalid,
  input  logic       tx_tready,
  input  logic [7:0] rx_tdata,
  input  logic       rx_tvalid,
  output logic       rx_tready,
  input  logic       missed_ack
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StRegCmd  = 4'd1;
  localparam logic [3:0] StRegData = 4'd2;
  localparam logic [3:0] StWrCmd   = 4'd3;
  localparam logic [3:0] StWrData  = 4'd4;
  localparam logic [3:0] StRdCmd   = 4'd5;
  localparam logic [3:0] StRdData  = 4'd6;
  localparam logic [3:0] StAbort   = 4'd7;
  localparam logic [3:0] StResp    = 4'd8;

`ifdef I2C_REG_SEQUENCER_RETRY_EN
  localparam bit RetryEn = 1'b1;
`else
  localparam bit RetryEn = 1'b0;
`endif
  localparam logic [2:0] RetryMax = 3'(RETRY_MAX);

  logic [3:0] state_q, state_d;
  logic [2:0] attempt_q, attempt_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic       read_q, read_d;
  logic [7:0] rdata_q, rdata_d;
  logic       err_q, err_d;
  logic       in_xfer;

  assign in_xfer = (state_q >= StRegCmd) && (state_q <= StRdData);

  always_comb begin
    state_d   = state_q;
    attempt_d = attempt_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          dev_d     = req_dev_addr;
          reg_d     = req_reg_addr;
          wdata_d   = req_wdata;
          read_d    = req_read;
          attempt_d = 3'd0;
          state_d   = StRegCmd;
        end
      end
      StRegCmd:  if (cmd_ready) state_d = StRegData;
      StRegData: if (tx_tready) state_d = read_q ? StRdCmd : StWrCmd;
      StWrCmd:   if (cmd_ready) state_d = StWrData;
      StWrData: begin
        if (tx_tready) begin
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StRdCmd:   if (cmd_ready) state_d = StRdData;
      StRdData: begin
        if (rx_tvalid) begin
          rdata_d = rx_tdata;
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StAbort: begin
        if (cmd_ready) begin
          attempt_d = (attempt_q == 3'd7) ? attempt_q : attempt_q + 3'd1;
          if (RetryEn && (attempt_q < RetryMax)) begin
            state_d = StRegCmd;
          end else begin
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // A NACK outranks any handshake completing in the same cycle.
    if (in_xfer && missed_ack) begin
      state_d = StAbort;
      rdata_d = rdata_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      attempt_q <= 3'd0;
      dev_q     <= 7'd0;
      reg_q     <= 8'd0;
      wdata_q   <= 8'd0;
      read_q    <= 1'b0;
      rdata_q   <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      attempt_q <= attempt_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    req_ready   = (state_q == StIdle);
    rsp_valid   = (state_q == StResp);
    rsp_error   = (state_q == StResp) && err_q;
    rsp_rdata   = rdata_q;
    cmd_address = 7'd0;
    cmd_start   = 1'b0;
    cmd_read    = 1'b0;
    cmd_write   = 1'b0;
    cmd_stop    = 1'b0;
    cmd_valid   = 1'b0;
    tx_tdata    = 8'd0;
    tx_tvalid   = 1'b0;
    rx_tready   = 1'b0;
    case (state_q)
      StRegCmd: begin
        cmd_valid   = 1'b1;
        cmd_address = dev_q;
        cmd_start   = 1'b1;
        cmd_write   = 1'b1;
      end
      StRegData: begin
        tx_tvalid = 1'b1;
        tx_tdata  = reg_q;
      end
      StWrCmd: begin
        cmd_valid   = 1'b1;
        cmd_address = dev_q;
        cmd_write   = 1'b1;
        cmd_stop    = 1'b1;
      end
      StWrData: begin
        tx_tvalid = 1'b1;
        tx_tdata  = wdata_q;
      end
      StRdCmd: begin
        cmd_valid   = 1'b1;
        cmd_address = dev_q;
        cmd_start   = 1'b1;
        cmd_read    = 1'b1;
        cmd_stop    = 1'b1;
      end
      StRdData: rx_tready = 1'b1;
      StAbort: begin
        cmd_valid   = 1'b1;
        cmd_address = dev_q;
        cmd_stop    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
